mac_ctrl_seq: RTL and testbench
===============================

Name: mac_ctrl_seq

Overview:
Sequencer directly upstream of the MAC unit. It accepts a job (mode, term count), pulls operand pairs over a valid/ready stream and drives the MAC control/data inputs one term every 2 cycles, respecting the MAC's 2-register feedback latency. It captures the final MAC output and presents it on a valid/ready result port. Two modes:
- sump (mode 0): sum of a_i*b_i.
- tri (mode 1): Horner polynomial r = r*x + c_i.

Parameters:
LEN_W, 4, width of cfg_len (max terms 2^LEN_W-1)
TIMEOUT, 255, stall cycles before abort (used only with MAC_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  job request, sampled in IDLE only
cfg_mode  in  1  0=sump, 1=tri, latched on start
cfg_len  in  LEN_W  number of terms, latched on start
op_valid  in  1  operand pair valid
op_ready  out  1  operand pair accepted when op_valid&&op_ready
op_a  in  8  sump: multiplicand a_i; tri: coefficient c_i (highest order first)
op_b  in  8  sump: multiplier b_i; tri: x
mac_in_1  out  8  to MAC in_1
mac_in_2  out  8  to MAC in_2
mac_in_add  out  8  to MAC in_add
mac_mode  out  1  to MAC mode (latched cfg_mode)
mac_mul_input_mux  out  1  to MAC mul_input_mux
mac_adder_input_mux  out  1  to MAC adder_input_mux
mac_result  in  17  from MAC mac_output
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid&&res_ready
res_data  out  17  captured result
res_err  out  1  job aborted (timeout); 0 without macro
busy  out  1  high in any state except IDLE

Behaviour:
- Single clock domain.
- Reset: synchronous, active-high.
- Reset values:
  - State IDLE.
  - op_ready=0, res_valid=0, res_err=0, busy=0, res_data=0, mac_mode=0.
  - MAC outputs at PARK.
- PARK drive: in_1=0, in_2=0, in_add=0, mul_mux=0, add_mux=1. The MAC then recirculates its register and holds its value.
- All mac_* outputs are registered.
- Term encoding, registered on each op handshake:
  - sump term0: in_1=a, in_2=b, mul_mux=0, add_mux=0, in_add=0.
  - sump term k>0: same, but add_mux=1.
  - tri term0: in_1=0, in_2=x, mul_mux=0, add_mux=0, in_add=c.
  - tri term k>0: in_2=x, mul_mux=1, add_mux=0, in_add=c, in_1=0.
- Term0 never uses feedback, so no MAC clear is needed.
- States:
  - IDLE: PARK. If start && cfg_len!=0: latch mode/len, cnt=0 -> FETCH. start with cfg_len==0 is ignored.
  - FETCH: op_ready=1, PARK while no handshake. On handshake: register term, cnt++ -> HOLD1.
  - HOLD1: term held, op_ready=0 -> HOLD2.
  - HOLD2: term held. op_ready=(cnt<len).
    - On handshake: register next term -> HOLD1 (back-to-back, 2 cycles/term).
    - Else if cnt<len -> FETCH (PARK).
    - Else -> CAPTURE.
  - CAPTURE: PARK. res_data<=mac_result at end of cycle -> DONE.
  - DONE: res_valid=1. res_data and res_err stable until res_ready -> IDLE.
- Latency: res_valid rises 3 cycles after the last op handshake edge.
- start outside IDLE is ignored.
- Arithmetic (16-bit product truncation, 17-bit sum wrap) is owned by the MAC. The controller passes mac_result unchanged.
- Reset mid-job: return to IDLE/PARK next cycle and discard the partial job. No assumption is made about MAC register content.

Optional Feature:
MAC_CTRL_TIMEOUT_EN:
- Defined: a stall counter runs in FETCH and clears on handshake or state exit. Reaching TIMEOUT -> CAPTURE, then DONE with res_err=1 and res_data = the partial result.
- Undefined: no counter, res_err tied 0, FETCH waits forever.

Decomposition:
- Package mac_ctrl_pkg holds:
  - FSM state enum (IDLE, FETCH, HOLD1, HOLD2, CAPTURE, DONE).
  - Constants DATA_W=8, RES_W=17, MODE_SUMP=0, MODE_TRI=1.
  - PARK field values.
- No sub-module: a single FSM plus term counter.

Test Plan:
- Sump, len=3, pairs (2,3),(4,5),(10,10) back-to-back -> handshakes 2 cycles apart; res_data=126 with res_valid 3 cycles after the last handshake.
- Tri, len=3, x=2, coefs 1,2,3 -> res_data=11 (1 -> 4 -> 11).
- Sump, len=2, (255,255) twice, op_valid low 5 cycles between them -> res_data=130050; MAC output constant during stall.
- res_ready low 4 cycles in DONE, start pulsed -> res_valid/res_data held, start ignored; after ready, IDLE, and the next start is accepted.
- Reset asserted in HOLD1 of a sump job -> next cycle IDLE, PARK, op_ready=0. A new sump len=1 (7,9) then gives 63.
- cfg_len=0 start -> busy stays 0. With MAC_CTRL_TIMEOUT_EN and TIMEOUT=10, len=2 with only 1 op sent -> res_err=1, res_data = first product.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC sequencer: FSM states, MAC drive bundle,
// PARK drive values and the per-term MAC encoding.
package mac_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 17;

    localparam logic MODE_SUMP = 1'b0;
    localparam logic MODE_TRI  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD1,
        ST_HOLD2,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] in_1;
        logic [DATA_W-1:0] in_2;
        logic [DATA_W-1:0] in_add;
        logic              mul_mux;
        logic              add_mux;
    } mac_drive_t;

    localparam logic [DATA_W-1:0] PARK_IN_1    = '0;
    localparam logic [DATA_W-1:0] PARK_IN_2    = '0;
    localparam logic [DATA_W-1:0] PARK_IN_ADD  = '0;
    localparam logic              PARK_MUL_MUX = 1'b0;
    localparam logic              PARK_ADD_MUX = 1'b1;

    // Zero product plus fed-back register: the MAC holds its value.
    localparam mac_drive_t MAC_PARK = '{
        in_1:    PARK_IN_1,
        in_2:    PARK_IN_2,
        in_add:  PARK_IN_ADD,
        mul_mux: PARK_MUL_MUX,
        add_mux: PARK_ADD_MUX
    };

    function automatic mac_drive_t term_drive(
        input logic              mode,
        input logic              first,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        mac_drive_t d;
        d = MAC_PARK;
        if (mode == MODE_TRI) begin
            d.in_1    = '0;
            d.in_2    = b;
            d.in_add  = a;
            d.mul_mux = !first;
            d.add_mux = 1'b0;
        end else begin
            d.in_1    = a;
            d.in_2    = b;
            d.in_add  = '0;
            d.mul_mux = 1'b0;
            d.add_mux = !first;
        end
        return d;
    endfunction

endpackage

// File: rtl/mac_ctrl_seq.sv
// Job sequencer feeding the MAC one term every 2 cycles and returning its result.
// Optional stall abort enabled by defining MAC_CTRL_TIMEOUT_EN.
module mac_ctrl_seq
    import mac_ctrl_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cfg_mode,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] mac_in_1,
    output logic [DATA_W-1:0] mac_in_2,
    output logic [DATA_W-1:0] mac_in_add,
    output logic              mac_mode,
    output logic              mac_mul_input_mux,
    output logic              mac_adder_input_mux,
    input  logic [RES_W-1:0]  mac_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              res_err,
    output logic              busy
);

    if (TIMEOUT < 1 || LEN_W < 1) begin : g_param_check
        $error("mac_ctrl_seq: TIMEOUT and LEN_W must be at least 1");
    end

    state_t           state;
    mac_drive_t       drv;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             op_hs;
    logic             stall_hit;
    logic             timed_out;

    assign op_hs = op_valid && op_ready;

    assign mac_in_1            = drv.in_1;
    assign mac_in_2            = drv.in_2;
    assign mac_in_add          = drv.in_add;
    assign mac_mul_input_mux   = drv.mul_mux;
    assign mac_adder_input_mux = drv.add_mux;

`ifdef MAC_CTRL_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q;

    assign stall_hit = (state == ST_FETCH) && !op_hs && (stall_q == STALL_W'(TIMEOUT - 1));

    // Counts consecutive FETCH cycles without a handshake; any exit clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == ST_FETCH && !op_hs && !stall_hit) begin
                stall_q <= stall_q + 1'b1;
            end else begin
                stall_q <= '0;
            end
            if (state == ST_IDLE) begin
                timed_out <= 1'b0;
            end else if (stall_hit) begin
                timed_out <= 1'b1;
            end
        end
    end
`else
    assign stall_hit = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            drv       <= MAC_PARK;
            len_q     <= '0;
            cnt_q     <= '0;
            op_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_data  <= '0;
            mac_mode  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    drv <= MAC_PARK;
                    if (start && cfg_len != '0) begin
                        mac_mode <= cfg_mode;
                        len_q    <= cfg_len;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        op_ready <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (op_hs) begin
                        drv      <= term_drive(mac_mode, cnt_q == '0, op_a, op_b);
                        cnt_q    <= cnt_q + 1'b1;
                        op_ready <= 1'b0;
                        state    <= ST_HOLD1;
                    end else if (stall_hit) begin
                        op_ready <= 1'b0;
                        state    <= ST_CAPTURE;
                    end
                end
                ST_HOLD1: begin
                    op_ready <= (cnt_q < len_q);
                    state    <= ST_HOLD2;
                end
                // The MAC feedback is valid again here, so the next term may follow at once.
                ST_HOLD2: begin
                    if (op_hs) begin
                        drv      <= term_drive(mac_mode, cnt_q == '0, op_a, op_b);
                        cnt_q    <= cnt_q + 1'b1;
                        op_ready <= 1'b0;
                        state    <= ST_HOLD1;
                    end else begin
                        drv   <= MAC_PARK;
                        state <= (cnt_q < len_q) ? ST_FETCH : ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    res_data  <= mac_result;
                    res_err   <= timed_out;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_err   <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    drv      <= MAC_PARK;
                    op_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_ctrl_seq.sv
// Directed bench for mac_ctrl_seq with a behavioural 2-register MAC on its outputs.
// Define MAC_CTRL_TIMEOUT_EN to include the stall-abort step.
module tb_mac_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cfg_mode;
    logic [3:0]  cfg_len;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [7:0]  mac_in_1;
    logic [7:0]  mac_in_2;
    logic [7:0]  mac_in_add;
    logic        mac_mode;
    logic        mac_mul_input_mux;
    logic        mac_adder_input_mux;
    logic [16:0] mac_result;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_data;
    logic        res_err;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    int hs_cyc = 0;
    int prev_hs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    mac_ctrl_seq #(
        .LEN_W   (4),
        .TIMEOUT (10)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .cfg_mode            (cfg_mode),
        .cfg_len             (cfg_len),
        .op_valid            (op_valid),
        .op_ready            (op_ready),
        .op_a                (op_a),
        .op_b                (op_b),
        .mac_in_1            (mac_in_1),
        .mac_in_2            (mac_in_2),
        .mac_in_add          (mac_in_add),
        .mac_mode            (mac_mode),
        .mac_mul_input_mux   (mac_mul_input_mux),
        .mac_adder_input_mux (mac_adder_input_mux),
        .mac_result          (mac_result),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_data            (res_data),
        .res_err             (res_err),
        .busy                (busy)
    );

    // MAC: product+addend registered, then output register; feedback taken from the output register.
    logic [16:0] mac_s1 = '0;
    logic [16:0] mac_r  = '0;
    logic [24:0] mul_full;
    logic [16:0] addend;

    always_comb begin
        mul_full = mac_mul_input_mux ? 25'(mac_r) * 25'(mac_in_2)
                                     : 25'(mac_in_1) * 25'(mac_in_2);
        addend   = mac_adder_input_mux ? mac_r : 17'(mac_in_add);
    end

    always @(posedge clk) begin
        mac_s1 <= 17'(mul_full[15:0]) + addend;
        mac_r  <= mac_s1;
    end

    assign mac_result = mac_r;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic mode, input logic [3:0] len);
        start    = 1'b1;
        cfg_mode = mode;
        cfg_len  = len;
        cyc();
        start    = 1'b0;
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b);
        int n;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        n        = 0;
        while (!op_ready && n < 50) begin
            cyc();
            n++;
        end
        chk("hs_wait", 32'(op_ready), 32'd1);
        cyc();
        hs_cyc   = cyc_n;
        op_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 40) begin
            cyc();
            n++;
        end
        chk(tag, 32'(res_valid), 32'd1);
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        chk("release_valid", 32'(res_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cfg_mode  = 1'b0;
        cfg_len   = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_op_ready",  32'(op_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_err",   32'(res_err), 32'd0);
        chk("rst_res_data",  32'(res_data), 32'd0);
        chk("rst_mac_mode",  32'(mac_mode), 32'd0);
        chk("rst_park", 32'({mac_in_1, mac_in_2, mac_in_add, mac_mul_input_mux, mac_adder_input_mux}), 32'd1);
        reset = 1'b0;
        cyc();

        // Zero-length job is ignored.
        start_job(1'b0, 4'd0);
        chk("len0_busy",     32'(busy), 32'd0);
        chk("len0_op_ready", 32'(op_ready), 32'd0);

        // Sump, back-to-back: 2*3 + 4*5 + 10*10 = 126.
        start_job(1'b0, 4'd3);
        chk("sump_busy",     32'(busy), 32'd1);
        chk("sump_op_ready", 32'(op_ready), 32'd1);
        push_op(8'd2, 8'd3);
        chk("sump_t0_in_1",   32'(mac_in_1), 32'd2);
        chk("sump_t0_addmux", 32'(mac_adder_input_mux), 32'd0);
        prev_hs = hs_cyc;
        push_op(8'd4, 8'd5);
        chk("b2b_gap1",       hs_cyc - prev_hs, 32'd2);
        chk("sump_t1_addmux", 32'(mac_adder_input_mux), 32'd1);
        prev_hs = hs_cyc;
        push_op(8'd10, 8'd10);
        chk("b2b_gap2", hs_cyc - prev_hs, 32'd2);
        cyc();
        cyc();
        chk("sump_early_valid", 32'(res_valid), 32'd0);
        cyc();
        chk("sump_valid_lat3", 32'(res_valid), 32'd1);
        chk("sump_data",       32'(res_data), 32'd126);
        chk("sump_err",        32'(res_err), 32'd0);
        release_res();
        chk("sump_idle_busy", 32'(busy), 32'd0);

        // Tri, Horner x=2 coefs 1,2,3: 1 -> 4 -> 11.
        start_job(1'b1, 4'd3);
        chk("tri_mac_mode", 32'(mac_mode), 32'd1);
        push_op(8'd1, 8'd2);
        chk("tri_t0_in_add", 32'(mac_in_add), 32'd1);
        chk("tri_t0_mulmux", 32'(mac_mul_input_mux), 32'd0);
        push_op(8'd2, 8'd2);
        chk("tri_t1_mulmux", 32'(mac_mul_input_mux), 32'd1);
        chk("tri_t1_in_1",   32'(mac_in_1), 32'd0);
        push_op(8'd3, 8'd2);
        wait_res("tri_wait");
        chk("tri_data", 32'(res_data), 32'd11);
        release_res();

        // Sump with a 5-cycle operand gap: 2 * 65025 = 130050.
        start_job(1'b0, 4'd2);
        push_op(8'd255, 8'd255);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i >= 2) begin
                chk("stall_result", 32'(mac_result), 32'd65025);
                chk("stall_park",   32'({mac_in_1, mac_in_2, mac_adder_input_mux}), 32'd1);
            end
        end
        push_op(8'd255, 8'd255);
        wait_res("stall_wait");
        chk("stall_data", 32'(res_data), 32'd130050);

        // Result held while res_ready is low; start in DONE is ignored.
        cfg_mode = 1'b0;
        cfg_len  = 4'd1;
        for (int i = 0; i < 4; i++) begin
            start = (i == 1);
            cyc();
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data",  32'(res_data), 32'd130050);
        end
        start = 1'b0;
        release_res();
        chk("after_done_busy", 32'(busy), 32'd0);
        cyc();
        chk("start_ignored_busy", 32'(busy), 32'd0);
        start_job(1'b0, 4'd1);
        chk("restart_busy", 32'(busy), 32'd1);
        push_op(8'd3, 8'd4);
        wait_res("restart_wait");
        chk("restart_data", 32'(res_data), 32'd12);
        release_res();

        // Reset during HOLD1 abandons the job.
        start_job(1'b0, 4'd2);
        push_op(8'd5, 8'd5);
        chk("hold1_in_1", 32'(mac_in_1), 32'd5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_busy",     32'(busy), 32'd0);
        chk("mid_rst_op_ready", 32'(op_ready), 32'd0);
        chk("mid_rst_park", 32'({mac_in_1, mac_in_2, mac_in_add, mac_mul_input_mux, mac_adder_input_mux}), 32'd1);
        start_job(1'b0, 4'd1);
        push_op(8'd7, 8'd9);
        wait_res("post_rst_wait");
        chk("post_rst_data", 32'(res_data), 32'd63);
        chk("post_rst_err",  32'(res_err), 32'd0);
        release_res();

`ifdef MAC_CTRL_TIMEOUT_EN
        // Only one of two operands arrives: abort with partial result 6*7.
        start_job(1'b0, 4'd2);
        push_op(8'd6, 8'd7);
        wait_res("tmo_wait");
        chk("tmo_err",  32'(res_err), 32'd1);
        chk("tmo_data", 32'(res_data), 32'd42);
        release_res();
        chk("tmo_err_clear", 32'(res_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
